alu_operand_stage: RTL and testbench

- Parametrised successor to the single-bit ALU source mux: selects ALU operands A and B, with EX/MEM and MEM/WB forwarding and an immediate select.
- Holds the result in a one-entry registered stage with valid/ready handshake, flush and backpressure.
- Sits between the ID/EX pipeline register and the ALU; supplies op_a, op_b and store data for STUR-class instructions.

---
 rtl/alu_operand_stage.sv | 173 +++++++++++++++++
 tb/tb_alu_operand_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Purpose:
//   Selects the ALU operands A and B, with EX/MEM and MEM/WB forwarding and an
//   immediate select. The selected operands are held in a one-entry registered
//   stage. The stage has a valid/ready handshake, flush and backpressure. It
//   sits between the ID/EX pipeline register and the ALU. It also supplies the
//   forwarded Rm value as store data for STUR-class instructions.
//
// Handshake:
//   A transfer happens on a rising edge when valid && ready are both high.
//   Upstream:   accept = in_valid && in_ready && !flush.
//               in_ready = !out_valid || out_ready. It never looks at in_valid.
//   Downstream: the entry is consumed when out_valid && out_ready.
//   While out_valid && !out_ready, every output holds its value.
//   flush drops the held entry and the current input on the next edge.
//
// Optional feature (macro ALU_OPND_HWSHIFT_EN):
//   When the macro is defined and alusrc=1, op_b = imm << (16*imm_hw),
//   truncated to DATA_W. This is the MOVZ/MOVK-style operand. When the macro
//   is undefined, imm_hw is ignored.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid / in_ready           upstream handshake
//   flush                         discard the held entry and the current input
//   alusrc                        0: B = forwarded Rm, 1: B = immediate
//   rn_idx, rm_idx                source register indices
//   rn_data, rm_data              register-file values
//   imm, imm_hw                   sign-extended immediate, halfword shift field
//   exmem_wr/rd/data              EX/MEM forwarding source
//   memwb_wr/rd/data              MEM/WB forwarding source
//   out_valid / out_ready         downstream handshake
//   op_a, op_b, store_data        registered operands
//   fwd_a, fwd_b                  registered source select:
//                                 0 regfile, 1 MEM/WB, 2 EX/MEM
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int ZR_IDX = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              alusrc,
    input  logic [REG_AW-1:0] rn_idx,
    input  logic [REG_AW-1:0] rm_idx,
    input  logic [DATA_W-1:0] rn_data,
    input  logic [DATA_W-1:0] rm_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        imm_hw,
    input  logic              exmem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] store_data,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZR_IDX);
    localparam logic [1:0] SRC_RF    = 2'd0;
    localparam logic [1:0] SRC_MEMWB = 2'd1;
    localparam logic [1:0] SRC_EXMEM = 2'd2;

    logic              r_valid;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_store;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;

    logic              w_accept;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_rm;
    logic [DATA_W-1:0] w_imm_op;
    logic [DATA_W-1:0] w_b;

    // Forwarding for operand A. EX/MEM is the younger producer, so it wins
    // over MEM/WB. The zero register is never forwarded, because upstream
    // already drives its register-file value as 0.
    always_comb begin
        w_sel_a = SRC_RF;
        w_a     = rn_data;
        if (rn_idx != ZR) begin
            if (exmem_wr && (exmem_rd == rn_idx)) begin
                w_sel_a = SRC_EXMEM;
                w_a     = exmem_data;
            end else if (memwb_wr && (memwb_rd == rn_idx)) begin
                w_sel_a = SRC_MEMWB;
                w_a     = memwb_data;
            end
        end
    end

    // Forwarding for Rm. It uses the same rules as operand A.
    always_comb begin
        w_sel_b = SRC_RF;
        w_rm    = rm_data;
        if (rm_idx != ZR) begin
            if (exmem_wr && (exmem_rd == rm_idx)) begin
                w_sel_b = SRC_EXMEM;
                w_rm    = exmem_data;
            end else if (memwb_wr && (memwb_rd == rm_idx)) begin
                w_sel_b = SRC_MEMWB;
                w_rm    = memwb_data;
            end
        end
    end

`ifdef ALU_OPND_HWSHIFT_EN
    // The shift amount is 0, 16, 32 or 48. Bits shifted past DATA_W are
    // dropped, so imm_hw=3 with a narrow DATA_W yields 0.
    logic [5:0] w_shamt;
    assign w_shamt  = {imm_hw, 4'b0000};
    assign w_imm_op = imm << w_shamt;
`else
    // imm_hw has no use in this build. It is folded into a sink so the
    // input stays part of the port list.
    logic w_unused_imm_hw;
    assign w_unused_imm_hw = ^imm_hw;
    assign w_imm_op        = imm;
`endif

    assign w_b      = alusrc ? w_imm_op : w_rm;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_store <= '0;
            r_fwd_a <= SRC_RF;
            r_fwd_b <= SRC_RF;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b1;
                r_op_a  <= w_a;
                r_op_b  <= w_b;
                r_store <= w_rm;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end else if (flush || out_ready) begin
                // The entry is flushed, or it is consumed with nothing new
                // behind it. The data registers keep their last value.
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign store_data = r_store;
    assign fwd_a      = r_fwd_a;
    assign fwd_b      = r_fwd_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    localparam int DATA_W = 64;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid, in_ready, flush, alusrc;
    logic [REG_AW-1:0] rn_idx, rm_idx, exmem_rd, memwb_rd;
    logic [DATA_W-1:0] rn_data, rm_data, imm, exmem_data, memwb_data;
    logic [1:0]        imm_hw;
    logic              exmem_wr, memwb_wr;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] op_a, op_b, store_data;
    logic [1:0]        fwd_a, fwd_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the held entry.
    logic              m_valid;
    logic [DATA_W-1:0] m_a, m_b, m_s;
    logic [1:0]        m_fa, m_fb;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZR_IDX(31)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .alusrc(alusrc), .rn_idx(rn_idx), .rm_idx(rm_idx),
        .rn_data(rn_data), .rm_data(rm_data), .imm(imm), .imm_hw(imm_hw),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .store_data(store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns the source that supplies register idx: 2 EX/MEM, 1 MEM/WB,
    // 0 regfile. Register 31 always reads the register file.
    function automatic logic [1:0] src_of(input logic [REG_AW-1:0] idx);
        if (idx == 5'd31) return 2'd0;
        if (exmem_wr && exmem_rd == idx) return 2'd2;
        if (memwb_wr && memwb_rd == idx) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [DATA_W-1:0] val_of(input logic [1:0] src,
                                                 input logic [DATA_W-1:0] rf);
        case (src)
            2'd2:    return exmem_data;
            2'd1:    return memwb_data;
            default: return rf;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] imm_operand();
`ifdef ALU_OPND_HWSHIFT_EN
        logic [DATA_W-1:0] mult;
        mult = 1;
        for (int k = 0; k < 16 * int'(imm_hw); k++) mult = mult * 2;
        return imm * mult;
`else
        return imm;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_s = 0; m_fa = 0; m_fb = 0;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_out_valid"}, DATA_W'(out_valid), DATA_W'(m_valid));
        check({pfx, "_op_a"}, op_a, m_a);
        check({pfx, "_op_b"}, op_b, m_b);
        check({pfx, "_store"}, store_data, m_s);
        check({pfx, "_fwd_a"}, DATA_W'(fwd_a), DATA_W'(m_fa));
        check({pfx, "_fwd_b"}, DATA_W'(fwd_b), DATA_W'(m_fb));
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; alusrc = 0; out_ready = 1;
        rn_idx = 0; rm_idx = 0; rn_data = 0; rm_data = 0; imm = 0; imm_hw = 0;
        exmem_wr = 0; exmem_rd = 0; exmem_data = 0;
        memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    // This task is entered just after a falling edge, with the inputs already
    // driven. It covers one rising edge and returns at the next falling edge.
    task automatic cycle(input string pfx);
        logic       acc;
        logic [1:0] sa, sb;
        logic [DATA_W-1:0] rm_v;
        #1;
        check({pfx, "_in_ready"}, DATA_W'(in_ready), DATA_W'(!m_valid || out_ready));
        acc  = in_valid && (!m_valid || out_ready) && !flush;
        sa   = src_of(rn_idx);
        sb   = src_of(rm_idx);
        rm_v = val_of(sb, rm_data);
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1;
            m_a  = val_of(sa, rn_data);
            m_s  = rm_v;
            m_b  = alusrc ? imm_operand() : rm_v;
            m_fa = sa;
            m_fb = sb;
        end else if (flush || out_ready) begin
            m_valid = 0;
        end
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic drive_random();
        in_valid   = ($urandom_range(0, 3) != 0);
        out_ready  = ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 9) == 0);
        alusrc     = $urandom_range(0, 1) == 1;
        rn_idx     = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        rm_idx     = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        rn_data    = (rn_idx == 5'd31) ? '0 : {$urandom, $urandom};
        rm_data    = (rm_idx == 5'd31) ? '0 : {$urandom, $urandom};
        imm        = {$urandom, $urandom};
        imm_hw     = 2'($urandom_range(0, 3));
        exmem_wr   = $urandom_range(0, 1) == 1;
        exmem_rd   = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        exmem_data = {$urandom, $urandom};
        memwb_wr   = $urandom_range(0, 1) == 1;
        memwb_rd   = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
        memwb_data = {$urandom, $urandom};
    endtask

    initial begin
        set_idle();
        reset_n = 0;
        model_reset();
        #2;
        check_outputs("reset");
        @(negedge clk);
        reset_n = 1;

        // Both sources hit; EX/MEM must win.
        set_idle();
        in_valid = 1; rn_idx = 3; rn_data = 64'h11;
        exmem_wr = 1; exmem_rd = 3; exmem_data = 64'hAA;
        memwb_wr = 1; memwb_rd = 3; memwb_data = 64'hBB;
        cycle("prio");
        check("prio_op_a_const", op_a, 64'hAA);
        check("prio_fwd_a_const", DATA_W'(fwd_a), 2);

        // The zero register is never forwarded.
        set_idle();
        in_valid = 1; rm_idx = 31; rm_data = 0;
        exmem_wr = 1; exmem_rd = 31; exmem_data = 64'h77;
        cycle("zr");
        check("zr_op_b_const", op_b, 0);
        check("zr_store_const", store_data, 0);
        check("zr_fwd_b_const", DATA_W'(fwd_b), 0);

        // The immediate goes to B; store_data still carries forwarded Rm.
        set_idle();
        in_valid = 1; alusrc = 1; imm = 64'hFFFF_FFFF_FFFF_FFF8;
        rm_idx = 4; rm_data = 64'h9; memwb_wr = 1; memwb_rd = 4; memwb_data = 64'h123;
        cycle("immst");
        check("immst_op_b_const", op_b, 64'hFFFF_FFFF_FFFF_FFF8);
        check("immst_store_const", store_data, 64'h123);
        check("immst_fwd_b_const", DATA_W'(fwd_b), 1);

        // Halfword shift of the immediate.
        set_idle();
        in_valid = 1; alusrc = 1; imm = 64'h1234; imm_hw = 2;
        cycle("hw");
`ifdef ALU_OPND_HWSHIFT_EN
        check("hw_op_b_const", op_b, 64'h0000_1234_0000_0000);
`else
        check("hw_op_b_const", op_b, 64'h1234);
`endif

        // Backpressure: the entry is held for three cycles.
        set_idle();
        in_valid = 1; rn_idx = 2; rn_data = 64'h5A5A;
        cycle("bp_load");
        for (int i = 0; i < 3; i++) begin
            out_ready = 0; in_valid = 1; rn_idx = 1; rn_data = 64'(i + 100);
            #1;
            check("bp_in_ready_low", DATA_W'(in_ready), 0);
            cycle("bp_hold");
            check("bp_op_a_stable", op_a, 64'h5A5A);
        end
        // The stream then runs back to back with no bubble.
        for (int i = 0; i < 2; i++) begin
            out_ready = 1; in_valid = 1; rn_data = 64'(i + 200);
            cycle("b2b");
            check("b2b_valid", DATA_W'(out_valid), 1);
            check("b2b_op_a", op_a, 64'(i + 200));
        end
        // flush with in_valid set drops everything.
        flush = 1; in_valid = 1; out_ready = 0; rn_data = 64'h999;
        cycle("flush");
        check("flush_valid_low", DATA_W'(out_valid), 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive_random();
            cycle("rnd");
        end

        // Reset in the middle of a hold acts immediately.
        set_idle();
        in_valid = 1; rn_idx = 1; rn_data = 64'h5;
        cycle("rst_load");
        in_valid = 0; out_ready = 0;
        cycle("rst_hold");
        check("rst_hold_op_a", op_a, 64'h5);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge clk);
        reset_n = 1;
        set_idle();
        in_valid = 1; rn_idx = 6; rn_data = 64'h66;
        cycle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
